// File: rtl/booth_r4_mul.sv
// Radix-4 (modified) Booth sequential multiplier: one Booth digit (two multiplier bits) per clock.
// Signed or unsigned operands, start/busy/done handshake, registered 2W-bit product.
module booth_r4_mul #(
   parameter  int W  = 8,
   localparam int CW = $clog2(W/2+2)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic           mode_signed,
   input  logic [W-1:0]   op_m,
   input  logic [W-1:0]   op_q,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] product
);

   if ((W % 2) != 0 || W < 4) begin : g_bad_width
      $error("booth_r4_mul: W must be even and >= 4");
   end

   // Handshake: start is accepted on a rising edge only in IDLE or DONE; done pulses for
   // exactly one cycle when product is valid, and product holds until the next completion.
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state;
   logic [W+1:0]    m_reg;
   logic [W+1:0]    a_reg;
   logic [W+1:0]    q_reg;
   logic            q_1;
   logic [CW-1:0]   cnt;
   logic            sgn;

   logic [2:0]      digit;
   logic [W+1:0]    m2;
   logic [W+1:0]    addend;
   logic            sub;
   logic [W+1:0]    a_sum;
   logic [W+1:0]    a_next;
   logic [W+1:0]    q_next;
   logic [2*W-1:0]  prod_next;
   logic [W+1:0]    m_ext;
   logic [W+1:0]    q_ext;

   assign digit = {q_reg[1:0], q_1};
   assign m2    = {m_reg[W:0], 1'b0};

   always_comb begin
      addend = '0;
      sub    = 1'b0;
      case (digit)
         3'b001, 3'b010: addend = m_reg;
         3'b011:         addend = m2;
         3'b100: begin
            addend = m2;
            sub    = 1'b1;
         end
         3'b101, 3'b110: begin
            addend = m_reg;
            sub    = 1'b1;
         end
         default:        addend = '0;
      endcase
   end

   always_comb begin
      a_sum  = sub ? (a_reg - addend) : (a_reg + addend);
      a_next = {{2{a_sum[W+1]}}, a_sum[W+1:2]};
      q_next = {a_sum[1:0], q_reg[W+1:2]};
      // Signed mode runs one digit fewer, so the product ends two bits higher in {A,Q}.
      if (sgn) prod_next = {a_next[W-1:0], q_next[W+1:2]};
      else     prod_next = {a_next[W-3:0], q_next};
   end

   assign m_ext = mode_signed ? {{2{op_m[W-1]}}, op_m} : {2'b00, op_m};
   assign q_ext = mode_signed ? {{2{op_q[W-1]}}, op_q} : {2'b00, op_q};

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         m_reg   <= '0;
         a_reg   <= '0;
         q_reg   <= '0;
         q_1     <= 1'b0;
         cnt     <= '0;
         sgn     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  m_reg <= m_ext;
                  a_reg <= '0;
                  q_reg <= q_ext;
                  q_1   <= 1'b0;
                  sgn   <= mode_signed;
                  cnt   <= mode_signed ? CW'(W/2) : CW'(W/2+1);
                  busy  <= 1'b1;
                  state <= CALC;
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               a_reg <= a_next;
               q_reg <= q_next;
               q_1   <= q_reg[1];
               cnt   <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  product <= prod_next;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state   <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_r4_mul.sv
// Bench for booth_r4_mul: W=8 directed vectors and handshake corner cases, W=16 random
// regression against a plain-arithmetic reference multiply.
module tb_booth_r4_mul;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        start8, ms8;
   logic [7:0]  m8, q8;
   logic        busy8, done8;
   logic [15:0] p8;

   logic        start16, ms16;
   logic [15:0] m16, q16;
   logic        busy16, done16;
   logic [31:0] p16;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   logic cnt_en = 1'b0;

   logic [31:0] exp_q[$];

   booth_r4_mul #(.W(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .mode_signed(ms8),
      .op_m(m8), .op_q(q8), .busy(busy8), .done(done8), .product(p8)
   );

   booth_r4_mul #(.W(16)) dut16 (
      .clk(clk), .reset(reset), .start(start16), .mode_signed(ms16),
      .op_m(m16), .op_q(q16), .busy(busy16), .done(done16), .product(p16)
   );

   always @(negedge clk) if (cnt_en && done8 === 1'b1) done_cnt++;

   typedef struct {
      logic        ms;
      logic [7:0]  m;
      logic [7:0]  q;
      logic [15:0] exp_p;
      int          exp_lat;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_mul16(input logic ms, input logic [15:0] a, input logic [15:0] b);
      longint x, y;
      if (ms) begin
         x = longint'($signed(a));
         y = longint'($signed(b));
      end else begin
         x = longint'(a);
         y = longint'(b);
      end
      return 32'(x * y);
   endfunction

   function automatic logic [15:0] pick16();
      case ($urandom_range(0, 7))
         0:       return 16'h8000;
         1:       return 16'hFFFF;
         2:       return 16'h7FFF;
         3:       return 16'h0000;
         default: return 16'($urandom);
      endcase
   endfunction

   // Called at a negedge; returns at the negedge where done is seen (or the bound expires).
   task automatic run8(input logic ms, input logic [7:0] m, input logic [7:0] q,
                       output logic [15:0] p, output int lat, output int busy_n);
      start8 = 1'b1; ms8 = ms; m8 = m; q8 = q;
      @(negedge clk);
      start8 = 1'b0;
      m8 = 8'($urandom); q8 = 8'($urandom); ms8 = 1'($urandom);
      lat = 0; busy_n = 0;
      while (done8 !== 1'b1 && lat < 40) begin
         if (busy8 === 1'b1) busy_n++;
         @(negedge clk);
         lat++;
      end
      p = p8;
   endtask

   task automatic run16(input logic ms, input logic [15:0] m, input logic [15:0] q,
                        input logic [31:0] prev, output logic [31:0] got_exp);
      int k;
      exp_q.push_back(ref_mul16(ms, m, q));
      start16 = 1'b1; ms16 = ms; m16 = m; q16 = q;
      @(negedge clk);
      start16 = 1'b0;
      m16 = 16'($urandom); q16 = 16'($urandom); ms16 = 1'($urandom);
      check("hold16_calc", p16, prev);
      k = 0;
      while (done16 !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("lat16", k, ms ? 8 : 9);
      got_exp = exp_q.pop_front();
      check("prod16", p16, got_exp);
   endtask

   initial begin
      logic [15:0] p;
      logic [31:0] prev, e;
      int lat, busy_n, k, idle;
      logic ms;

      vecs[0] = '{1'b1, 8'h07, 8'hFD, 16'hFFEB, 4};
      vecs[1] = '{1'b1, 8'h80, 8'h80, 16'h4000, 4};
      vecs[2] = '{1'b1, 8'h80, 8'h7F, 16'hC080, 4};
      vecs[3] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 5};
      vecs[4] = '{1'b0, 8'h80, 8'h02, 16'h0100, 5};
      vecs[5] = '{1'b1, 8'h03, 8'h05, 16'h000F, 4};
      vecs[6] = '{1'b0, 8'h00, 8'hFF, 16'h0000, 5};
      vecs[7] = '{1'b1, 8'hFF, 8'hFF, 16'h0001, 4};
      vecs[8] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01, 4};
      vecs[9] = '{1'b0, 8'hFF, 8'h01, 16'h00FF, 5};

      reset = 1'b1;
      start8 = 1'b0; ms8 = 1'b0; m8 = '0; q8 = '0;
      start16 = 1'b0; ms16 = 1'b0; m16 = '0; q16 = '0;
      repeat (3) @(negedge clk);
      check("rst_busy8", busy8, 0);
      check("rst_done8", done8, 0);
      check("rst_prod8", p8, 0);
      check("rst_busy16", busy16, 0);
      check("rst_done16", done16, 0);
      check("rst_prod16", p16, 0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         run8(vecs[i].ms, vecs[i].m, vecs[i].q, p, lat, busy_n);
         check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
         check($sformatf("vec%0d_busy", i), busy_n, vecs[i].exp_lat);
         check($sformatf("vec%0d_prod", i), p, vecs[i].exp_p);
         @(negedge clk);
         check($sformatf("vec%0d_done_pulse", i), done8, 0);
         check($sformatf("vec%0d_hold", i), p8, vecs[i].exp_p);
      end

      // Back-to-back start in DONE, start held high and operands scrambled during CALC.
      done_cnt = 0;
      cnt_en   = 1'b1;
      start8 = 1'b1; ms8 = 1'b1; m8 = 8'h07; q8 = 8'hFD;
      @(negedge clk);
      start8 = 1'b0;
      k = 0;
      while (done8 !== 1'b1 && k < 40) begin @(negedge clk); k++; end
      check("b2b_first_lat", k, 4);
      check("b2b_first_prod", p8, 16'hFFEB);
      start8 = 1'b1; ms8 = 1'b1; m8 = 8'h03; q8 = 8'h05;
      @(negedge clk);
      k = 0;
      while (done8 !== 1'b1 && k < 40) begin
         m8 = 8'($urandom); q8 = 8'($urandom); ms8 = 1'($urandom);
         @(negedge clk);
         k++;
      end
      start8 = 1'b0;
      check("b2b_second_lat", k, 4);
      check("b2b_second_prod", p8, 16'h000F);
      repeat (6) @(negedge clk);
      cnt_en = 1'b0;
      check("b2b_done_pulses", done_cnt, 2);
      check("b2b_idle_busy", busy8, 0);

      // Reset during the second CALC cycle aborts with no done pulse.
      start8 = 1'b1; ms8 = 1'b0; m8 = 8'hFF; q8 = 8'hFF;
      @(negedge clk);
      start8 = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", busy8, 0);
      check("abort_done", done8, 0);
      check("abort_prod", p8, 0);
      done_cnt = 0;
      cnt_en   = 1'b1;
      repeat (7) @(negedge clk);
      cnt_en = 1'b0;
      check("abort_no_done", done_cnt, 0);
      check("abort_still_idle", busy8, 0);
      run8(1'b1, 8'h07, 8'hFD, p, lat, busy_n);
      check("post_abort_lat", lat, 4);
      check("post_abort_prod", p, 16'hFFEB);
      @(negedge clk);

      // Reset wins over start in the same cycle.
      reset = 1'b1; start8 = 1'b1; ms8 = 1'b1; m8 = 8'h11; q8 = 8'h22;
      @(negedge clk);
      reset = 1'b0; start8 = 1'b0;
      check("rst_over_start_busy", busy8, 0);
      check("rst_over_start_prod", p8, 0);
      @(negedge clk);
      check("rst_over_start_busy2", busy8, 0);

      // W=16 random regression with scoreboard.
      prev = 32'h0;
      for (int i = 0; i < 1000; i++) begin
         ms = 1'($urandom);
         run16(ms, pick16(), pick16(), prev, e);
         prev = e;
         idle = $urandom_range(0, 2);
         for (int j = 0; j < idle; j++) begin
            @(negedge clk);
            if (j == 0) check("done16_pulse", done16, 0);
            check("hold16_idle", p16, prev);
         end
      end
      check("scoreboard_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no end, expected end of test");
      $fatal(1, "watchdog");
   end

endmodule
